// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline-occupancy tracker.
package pipe_pkg;

   localparam int unsigned STAGES_DEF     = 3;
   localparam int unsigned LOAD_READY_DEF = 2;
   localparam int unsigned PERF_W         = 32;

   // Tag register fields are sized for the widest supported register index.
   localparam int unsigned TAG_AW = 8;
   localparam logic [TAG_AW-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic              valid;
      logic [TAG_AW-1:0] rd;
      logic              we;
      logic              load;
      logic [TAG_AW-1:0] rs1;
      logic [TAG_AW-1:0] rs2;
      logic              use1;
      logic              use2;
   } slot_tag_t;

endpackage

// File: rtl/pipe_match.sv
// Compares one source register against one slot tag; flags a producer hit and a load hit.
module pipe_match
   import pipe_pkg::*;
(
   input  logic              use_src,
   input  logic [TAG_AW-1:0] src,
   input  logic              valid,
   input  logic              we,
   input  logic              load,
   input  logic [TAG_AW-1:0] rd,
   output logic              hit,
   output logic              load_hit
);

   always_comb begin
      hit      = valid & we & (rd != REG_ZERO) & (rd == src) & use_src;
      load_hit = hit & load;
   end

endmodule

// File: rtl/pipe_track.sv
// Pipeline-occupancy tracker: load-use stall, flush bubble and forward selects.
// Optional PIPE_TRACK_PERF_EN adds saturating stall/flush/retire counters.
module pipe_track
   import pipe_pkg::*;
#(
   parameter int unsigned STAGES     = STAGES_DEF,
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned LOAD_READY = LOAD_READY_DEF,
   parameter int unsigned SW         = $clog2(STAGES)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_valid,
   input  logic [REG_AW-1:0] issue_rd,
   input  logic              issue_we,
   input  logic              issue_load,
   input  logic [REG_AW-1:0] issue_rs1,
   input  logic [REG_AW-1:0] issue_rs2,
   input  logic              issue_use1,
   input  logic              issue_use2,
   input  logic              flush,
   input  logic              hold,
   output logic              stall,
   output logic [SW-1:0]     fwd_rs1,
   output logic [SW-1:0]     fwd_rs2,
   output logic [STAGES-1:0] slot_valid,
   output logic              wb_valid,
   output logic              wb_we,
   output logic [REG_AW-1:0] wb_rd,
   output logic              busy
`ifdef PIPE_TRACK_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_stall,
   output logic [PERF_W-1:0] perf_flush,
   output logic [PERF_W-1:0] perf_retire
`endif
);

   slot_tag_t             slot_q [STAGES];
   slot_tag_t             slot_d [STAGES];
   slot_tag_t             issue_tag;
   logic [STAGES-1:0]     stall_vec;
   logic [STAGES-1:1]     fwd1_ok;
   logic [STAGES-1:1]     fwd2_ok;

   always_comb begin
      issue_tag       = '0;
      issue_tag.valid = issue_valid;
      issue_tag.rd    = TAG_AW'(issue_rd);
      issue_tag.we    = issue_we;
      issue_tag.load  = issue_load;
      issue_tag.rs1   = TAG_AW'(issue_rs1);
      issue_tag.rs2   = TAG_AW'(issue_rs2);
      issue_tag.use1  = issue_use1;
      issue_tag.use2  = issue_use2;
   end

   // Decode sources against loads too young to forward.
   for (genvar k = 0; k < STAGES; k++) begin : g_issue
      if (k + 1 < LOAD_READY) begin : g_chk
         logic h1, l1, h2, l2;
         pipe_match u_m1 (
            .use_src(issue_use1), .src(issue_tag.rs1),
            .valid(slot_q[k].valid), .we(slot_q[k].we), .load(slot_q[k].load), .rd(slot_q[k].rd),
            .hit(h1), .load_hit(l1));
         pipe_match u_m2 (
            .use_src(issue_use2), .src(issue_tag.rs2),
            .valid(slot_q[k].valid), .we(slot_q[k].we), .load(slot_q[k].load), .rd(slot_q[k].rd),
            .hit(h2), .load_hit(l2));
         assign stall_vec[k] = (h1 & l1) | (h2 & l2);
      end else begin : g_none
         assign stall_vec[k] = 1'b0;
      end
   end

   // Slot-0 sources against older producers; young loads are never legal sources.
   for (genvar k = 1; k < STAGES; k++) begin : g_fwd
      localparam logic LD_EXCL = (k < LOAD_READY);
      logic h1, l1, h2, l2;
      pipe_match u_f1 (
         .use_src(slot_q[0].valid & slot_q[0].use1), .src(slot_q[0].rs1),
         .valid(slot_q[k].valid), .we(slot_q[k].we), .load(slot_q[k].load), .rd(slot_q[k].rd),
         .hit(h1), .load_hit(l1));
      pipe_match u_f2 (
         .use_src(slot_q[0].valid & slot_q[0].use2), .src(slot_q[0].rs2),
         .valid(slot_q[k].valid), .we(slot_q[k].we), .load(slot_q[k].load), .rd(slot_q[k].rd),
         .hit(h2), .load_hit(l2));
      assign fwd1_ok[k] = h1 & ~(l1 & LD_EXCL);
      assign fwd2_ok[k] = h2 & ~(l2 & LD_EXCL);
   end

   always_comb begin
      stall = issue_valid & ~flush & (|stall_vec);
   end

   // Scan oldest to youngest so the youngest producer wins.
   always_comb begin
      fwd_rs1 = '0;
      fwd_rs2 = '0;
      for (int k = STAGES - 1; k >= 1; k--) begin
         if (fwd1_ok[k]) fwd_rs1 = SW'(k);
         if (fwd2_ok[k]) fwd_rs2 = SW'(k);
      end
   end

   always_comb begin
      slot_d = slot_q;
      if (!hold) begin
         for (int i = STAGES - 1; i >= 1; i--) slot_d[i] = slot_q[i-1];
         slot_d[0] = '0;
         if (!flush && !stall && issue_valid) slot_d[0] = issue_tag;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) slot_q[i] <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

   always_comb begin
      for (int i = 0; i < STAGES; i++) slot_valid[i] = slot_q[i].valid;
      busy     = |slot_valid;
      wb_valid = slot_q[STAGES-1].valid;
      wb_we    = slot_q[STAGES-1].valid & slot_q[STAGES-1].we;
      wb_rd    = slot_q[STAGES-1].valid ? REG_AW'(slot_q[STAGES-1].rd) : '0;
   end

`ifdef PIPE_TRACK_PERF_EN
   logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
   logic [PERF_W-1:0] perf_flush_q, perf_flush_d;
   logic [PERF_W-1:0] perf_retire_q, perf_retire_d;

   // Saturating event counters, frozen while the pipe is held.
   always_comb begin
      perf_stall_d  = perf_stall_q;
      perf_flush_d  = perf_flush_q;
      perf_retire_d = perf_retire_q;
      if (!hold) begin
         if (stall && perf_stall_q != '1)     perf_stall_d  = perf_stall_q + PERF_W'(1);
         if (flush && perf_flush_q != '1)     perf_flush_d  = perf_flush_q + PERF_W'(1);
         if (wb_valid && perf_retire_q != '1) perf_retire_d = perf_retire_q + PERF_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_q  <= '0;
         perf_flush_q  <= '0;
         perf_retire_q <= '0;
      end else begin
         perf_stall_q  <= perf_stall_d;
         perf_flush_q  <= perf_flush_d;
         perf_retire_q <= perf_retire_d;
      end
   end

   assign perf_stall  = perf_stall_q;
   assign perf_flush  = perf_flush_q;
   assign perf_retire = perf_retire_q;
`endif

endmodule

// File: tb/tb_pipe_track.sv
// Directed self-checking bench for pipe_track (STAGES=3, LOAD_READY=2).
module tb_pipe_track;

   logic       clk = 1'b0;
   logic       rst;
   logic       issue_valid, issue_we, issue_load, issue_use1, issue_use2;
   logic [4:0] issue_rd, issue_rs1, issue_rs2;
   logic       flush, hold;
   logic       stall;
   logic [1:0] fwd_rs1, fwd_rs2;
   logic [2:0] slot_valid;
   logic       wb_valid, wb_we, busy;
   logic [4:0] wb_rd;
`ifdef PIPE_TRACK_PERF_EN
   logic [31:0] perf_stall, perf_flush, perf_retire;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipe_track dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_we(issue_we),
      .issue_load(issue_load), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .issue_use1(issue_use1), .issue_use2(issue_use2),
      .flush(flush), .hold(hold),
      .stall(stall), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
      .slot_valid(slot_valid), .wb_valid(wb_valid), .wb_we(wb_we),
      .wb_rd(wb_rd), .busy(busy)
`ifdef PIPE_TRACK_PERF_EN
      ,
      .perf_stall(perf_stall), .perf_flush(perf_flush), .perf_retire(perf_retire)
`endif
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic issue(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                        input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2);
      issue_valid = v;  issue_rd = rd;  issue_we = we;  issue_load = ld;
      issue_rs1 = rs1;  issue_use1 = u1;  issue_rs2 = rs2;  issue_use2 = u2;
   endtask

   task automatic nop;
      issue(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
   endtask

   task automatic drain;
      nop();
      flush = 1'b0;
      hold  = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_reset;
      settle();
      checks++; if (stall !== 1'b0)      begin errors++; $display("FAIL reset_stall: got %0b want 0", stall); end
      checks++; if (fwd_rs1 !== 2'd0 || fwd_rs2 !== 2'd0)
                                         begin errors++; $display("FAIL reset_fwd: got %0d/%0d want 0/0", fwd_rs1, fwd_rs2); end
      checks++; if (slot_valid !== 3'b000) begin errors++; $display("FAIL reset_slot_valid: got %b want 000", slot_valid); end
      checks++; if (wb_valid !== 1'b0 || wb_we !== 1'b0 || wb_rd !== 5'd0)
                                         begin errors++; $display("FAIL reset_wb: got %0b %0b %0d want 0 0 0", wb_valid, wb_we, wb_rd); end
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
   endtask

   task automatic test_alu_chain;
      drain();
      issue(1, 5'd5, 1, 0, 5'd1, 1, 5'd2, 1);        // add x5
      tick();
      issue(1, 5'd8, 1, 0, 5'd5, 1, 5'd3, 1);        // sub x8, x5, x3
      settle();
      checks++; if (stall !== 1'b0)  begin errors++; $display("FAIL alu_no_stall: got %0b want 0", stall); end
      tick();
      nop(); settle();
      checks++; if (fwd_rs1 !== 2'd1) begin errors++; $display("FAIL alu_fwd1: got %0d want 1", fwd_rs1); end
      checks++; if (fwd_rs2 !== 2'd0) begin errors++; $display("FAIL alu_fwd_rf: got %0d want 0", fwd_rs2); end
      drain();
      issue(1, 5'd6, 1, 0, 5'd0, 0, 5'd0, 0);        // add x6
      tick();
      nop();
      tick();
      issue(1, 5'd8, 1, 0, 5'd6, 1, 5'd6, 1);        // sub x8, x6, x6
      tick();
      nop(); settle();
      checks++; if (fwd_rs1 !== 2'd2) begin errors++; $display("FAIL gap_fwd1: got %0d want 2", fwd_rs1); end
      checks++; if (fwd_rs2 !== 2'd2) begin errors++; $display("FAIL gap_fwd2: got %0d want 2", fwd_rs2); end
      checks++; if (wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_rd !== 5'd6)
                                      begin errors++; $display("FAIL gap_wb: got %0b %0b %0d want 1 1 6", wb_valid, wb_we, wb_rd); end
   endtask

   task automatic test_youngest;
      drain();
      issue(1, 5'd9, 1, 0, 5'd0, 0, 5'd0, 0);
      tick();
      issue(1, 5'd9, 1, 0, 5'd0, 0, 5'd0, 0);
      tick();
      issue(1, 5'd10, 1, 0, 5'd9, 1, 5'd0, 0);
      tick();
      nop(); settle();
      checks++; if (fwd_rs1 !== 2'd1) begin errors++; $display("FAIL youngest_fwd: got %0d want 1", fwd_rs1); end
   endtask

   task automatic test_load_use;
      drain();
      issue(1, 5'd7, 1, 1, 5'd1, 1, 5'd0, 0);        // lw x7
      tick();
      issue(1, 5'd10, 1, 0, 5'd7, 1, 5'd0, 0);       // add x10, x7
      settle();
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall_on: got %0b want 1", stall); end
      tick();
      settle();
      checks++; if (slot_valid !== 3'b010) begin errors++; $display("FAIL lu_bubble: got %b want 010", slot_valid); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_off: got %0b want 0", stall); end
      tick();
      nop(); settle();
      checks++; if (fwd_rs1 !== 2'd2) begin errors++; $display("FAIL lu_fwd: got %0d want 2", fwd_rs1); end
      checks++; if (slot_valid !== 3'b101) begin errors++; $display("FAIL lu_slots: got %b want 101", slot_valid); end
   endtask

   task automatic test_x0_unused;
      drain();
      issue(1, 5'd0, 1, 1, 5'd1, 1, 5'd0, 0);        // lw x0
      tick();
      issue(1, 5'd10, 1, 0, 5'd0, 1, 5'd0, 1);
      settle();
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL x0_stall: got %0b want 0", stall); end
      tick();
      nop(); settle();
      checks++; if (fwd_rs1 !== 2'd0) begin errors++; $display("FAIL x0_fwd: got %0d want 0", fwd_rs1); end
      drain();
      issue(1, 5'd11, 1, 0, 5'd0, 0, 5'd0, 0);
      tick();
      issue(1, 5'd12, 1, 0, 5'd3, 1, 5'd11, 0);      // rs2 matches but unused
      tick();
      nop(); settle();
      checks++; if (fwd_rs2 !== 2'd0) begin errors++; $display("FAIL unused_fwd2: got %0d want 0", fwd_rs2); end
      checks++; if (fwd_rs1 !== 2'd0) begin errors++; $display("FAIL nomatch_fwd1: got %0d want 0", fwd_rs1); end
   endtask

   task automatic test_flush_stall;
      drain();
      issue(1, 5'd7, 1, 1, 5'd1, 1, 5'd0, 0);
      tick();
      issue(1, 5'd10, 1, 0, 5'd7, 1, 5'd0, 0);
      flush = 1'b1;
      settle();
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %0b want 0", stall); end
      tick();
      flush = 1'b0;
      nop(); settle();
      checks++; if (slot_valid !== 3'b010) begin errors++; $display("FAIL flush_slots: got %b want 010", slot_valid); end
   endtask

   task automatic test_reset_midstream;
      drain();
      issue(1, 5'd1, 1, 0, 5'd0, 0, 5'd0, 0); tick();
      issue(1, 5'd2, 1, 0, 5'd0, 0, 5'd0, 0); tick();
      issue(1, 5'd3, 1, 0, 5'd0, 0, 5'd0, 0); tick();
      nop(); settle();
      checks++; if (slot_valid !== 3'b111) begin errors++; $display("FAIL fill_slots: got %b want 111", slot_valid); end
      #2 rst = 1'b1;
      #1;
      checks++; if (slot_valid !== 3'b000) begin errors++; $display("FAIL async_reset: got %b want 000", slot_valid); end
      tick();
      rst = 1'b0;
      tick();
      checks++; if (wb_valid !== 1'b0 || busy !== 1'b0)
                begin errors++; $display("FAIL post_reset: got wb_valid=%0b busy=%0b want 0 0", wb_valid, busy); end
   endtask

   task automatic test_hold;
      drain();
      rst = 1'b1; #1; rst = 1'b0;
      tick();
      issue(1, 5'd12, 1, 0, 5'd0, 0, 5'd0, 0); tick();
      issue(1, 5'd13, 1, 0, 5'd0, 0, 5'd0, 0); tick();
      issue(1, 5'd14, 1, 1, 5'd0, 0, 5'd0, 0); tick();   // load x14
      issue(1, 5'd15, 1, 0, 5'd14, 1, 5'd0, 0);          // uses x14
      hold = 1'b1; flush = 1'b1;
      settle();
      checks++; if (slot_valid !== 3'b111 || wb_rd !== 5'd12)
                begin errors++; $display("FAIL hold_pre: got %b rd=%0d want 111 rd=12", slot_valid, wb_rd); end
      for (int i = 0; i < 3; i++) begin
         tick(); settle();
         checks++; if (slot_valid !== 3'b111 || wb_rd !== 5'd12)
                   begin errors++; $display("FAIL hold_freeze%0d: got %b rd=%0d want 111 rd=12", i, slot_valid, wb_rd); end
         checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hold_flush_stall%0d: got %0b want 0", i, stall); end
`ifdef PIPE_TRACK_PERF_EN
         checks++; if (perf_stall !== 32'd0 || perf_flush !== 32'd0 || perf_retire !== 32'd0)
                   begin errors++; $display("FAIL hold_perf%0d: got %0d %0d %0d want 0 0 0", i, perf_stall, perf_flush, perf_retire); end
`endif
      end
      flush = 1'b0;
      settle();
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hold_stall_rep: got %0b want 1", stall); end
      tick();
      hold = 1'b0;
      settle();
      checks++; if (slot_valid !== 3'b111 || wb_rd !== 5'd12)
                begin errors++; $display("FAIL hold_last: got %b rd=%0d want 111 rd=12", slot_valid, wb_rd); end
      tick(); settle();
      checks++; if (slot_valid !== 3'b110 || wb_rd !== 5'd13)
                begin errors++; $display("FAIL hold_release: got %b rd=%0d want 110 rd=13", slot_valid, wb_rd); end
      tick();
      nop(); settle();
      checks++; if (fwd_rs1 !== 2'd2) begin errors++; $display("FAIL hold_fwd: got %0d want 2", fwd_rs1); end
      repeat (5) tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_drain: got %0b want 0", busy); end
`ifdef PIPE_TRACK_PERF_EN
      checks++; if (perf_retire !== 32'd4) begin errors++; $display("FAIL perf_retire: got %0d want 4", perf_retire); end
      checks++; if (perf_stall !== 32'd1)  begin errors++; $display("FAIL perf_stall: got %0d want 1", perf_stall); end
      checks++; if (perf_flush !== 32'd0)  begin errors++; $display("FAIL perf_flush: got %0d want 0", perf_flush); end
`endif
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; hold = 1'b0;
      nop();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      test_reset();
      test_alu_chain();
      test_youngest();
      test_load_use();
      test_x0_unused();
      test_flush_stall();
      test_reset_midstream();
      test_hold();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
